// File: rtl/t09_mode_pkg.sv
// Shared types, default parameters and sizing helper for the mode button bank.
// The classifier state enum is used by each channel's FSM.
package t09_mode_pkg;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      LONG     = 2'd2
   } press_state_e;

   localparam int unsigned DEF_NUM_CH            = 4;
   localparam int unsigned DEF_SYNC_STAGES       = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 4;
   localparam int unsigned DEF_LONG_PRESS_CYCLES = 16;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/t09_button_channel.sv
// One button path: synchroniser, debounce filter, short/long classifier and mode flag.
// IS_TOGGLE selects toggle behaviour (1) or a momentary flag that follows the stable level (0).
module t09_button_channel
   import t09_mode_pkg::*;
#(
   parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter bit          IS_TOGGLE         = 1'b1
) (
   input  logic clk,
   input  logic sync_reset,
   input  logic button_i,
   input  logic enable_i,
   input  logic clear_i,
   output logic mode_flag_o,
   output logic press_pulse_o,
   output logic long_pulse_o,
   output logic stable_o
);

   localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   stable_q, stable_d;
   press_state_e           state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   flag_q, flag_d;
   logic                   press_q, press_d;
   logic                   long_q, long_d;
   logic                   sync_bit, rise, fall, short_rel;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync_bit != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = sync_bit;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign rise = stable_d & ~stable_q;
   assign fall = ~stable_d & stable_q;

   // Events are decoded from the next stable level so pulses align with stable_o.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      long_d    = 1'b0;
      short_rel = 1'b0;
      case (state_q)
         RELEASED: begin
            if (rise) begin
               state_d = PRESSED;
               hold_d  = HOLD_W'(1);
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d   = RELEASED;
               short_rel = 1'b1;
            end else begin
               hold_d = (hold_q == HOLD_LONG) ? hold_q : hold_q + 1'b1;
               if (hold_d == HOLD_LONG) begin
                  state_d = LONG;
                  long_d  = 1'b1;
               end
            end
         end
         LONG: begin
            if (fall) state_d = RELEASED;
         end
         default: state_d = RELEASED;
      endcase
   end

   always_comb begin
      flag_d = flag_q;
      if (clear_i) begin
         flag_d = 1'b0;
      end else if (enable_i) begin
         if (IS_TOGGLE) begin
            if (long_d)         flag_d = 1'b0;
            else if (short_rel) flag_d = ~flag_q;
         end else begin
            flag_d = stable_d;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         sync_q   <= '0;
         db_cnt_q <= '0;
         stable_q <= 1'b0;
         state_q  <= RELEASED;
         hold_q   <= '0;
         flag_q   <= 1'b0;
         press_q  <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], button_i};
         db_cnt_q <= db_cnt_d;
         stable_q <= stable_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         flag_q   <= flag_d;
         press_q  <= press_d;
         long_q   <= long_d;
      end
   end

   assign mode_flag_o   = flag_q;
   assign press_pulse_o = press_q;
   assign long_pulse_o  = long_q;
   assign stable_o      = stable_q;

endmodule

// File: rtl/t09_mode_button_bank.sv
// Bank of independent debounced mode buttons feeding the game-control FSM.
// Each channel is a t09_button_channel; enable and clear_all are broadcast to all.
module t09_mode_button_bank
   import t09_mode_pkg::*;
#(
   parameter int unsigned       NUM_CH            = DEF_NUM_CH,
   parameter int unsigned       SYNC_STAGES       = DEF_SYNC_STAGES,
   parameter int unsigned       DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned       LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter logic [NUM_CH-1:0] TOGGLE_MASK       = {NUM_CH{1'b1}}
) (
   input  logic              clk,
   input  logic              sync_reset,
   input  logic [NUM_CH-1:0] button_i,
   input  logic              enable,
   input  logic              clear_all,
   output logic [NUM_CH-1:0] mode_flag,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] long_pulse,
   output logic [NUM_CH-1:0] stable_o
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      t09_button_channel #(
         .SYNC_STAGES       (SYNC_STAGES),
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
         .IS_TOGGLE         (TOGGLE_MASK[g])
      ) u_ch (
         .clk           (clk),
         .sync_reset    (sync_reset),
         .button_i      (button_i[g]),
         .enable_i      (enable),
         .clear_i       (clear_all),
         .mode_flag_o   (mode_flag[g]),
         .press_pulse_o (press_pulse[g]),
         .long_pulse_o  (long_pulse[g]),
         .stable_o      (stable_o[g])
      );
   end

endmodule

// File: doc/t09_mode_button_bank.md
Name: t09_mode_button_bank

Overview:
- Parametrised, multi-channel successor to the single-button obstacle toggle.
- Each of NUM_CH push-button inputs has its own path: synchroniser, debounce filter, short/long press classifier, and a per-channel mode flag.
- A short press toggles the channel's flag. A long press forces the flag off and is reported separately.
- Sits between the board push-buttons and the game-control FSM. Its flags replace the per-feature toggle blocks (obstacle, speed, etc.).

Parameters:
- NUM_CH, 4: number of independent button channels.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 4: consecutive disagreeing cycles required before the stable level flips (minimum 1).
- LONG_PRESS_CYCLES, 16: cycles of stable-high that classify a press as long (must be greater than DEBOUNCE_CYCLES).
- TOGGLE_MASK, {NUM_CH{1'b1}}:
  - bit i = 1: channel i is a toggle channel.
  - bit i = 0: channel i is momentary (flag follows the stable level).

Ports:
- clk  in  1  system clock.
- sync_reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- button_i  in  NUM_CH  raw asynchronous push-button levels, 1 = pressed.
- enable  in  1  when 0, press events do not change flags; filtering and classification continue.
- clear_all  in  1  synchronous clear of all mode flags.
- mode_flag  out  NUM_CH  per-channel mode flag.
- press_pulse  out  NUM_CH  one-cycle pulse on each debounced press.
- long_pulse  out  NUM_CH  one-cycle pulse when a press reaches long-press length.
- stable_o  out  NUM_CH  debounced button level.

Behaviour:
- Reset: when sync_reset = 1 at a clk edge, the following are all cleared to 0:
  - synchroniser stages, stable levels, debounce counters, hold counters, long-seen bits;
  - mode_flag, press_pulse, long_pulse, stable_o.
- Reset mid-press: the channel restarts from released. A button still held after reset must be re-debounced and produces a fresh press_pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Synchroniser: a SYNC_STAGES-deep shift register per channel produces sync[i].
- Debounce, per channel:
  - The counter increments while sync != stable and clears to 0 whenever sync == stable.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, stable flips at that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
  - Latency from a raw edge (held clean) to the stable flip is SYNC_STAGES+DEBOUNCE_CYCLES edges; 6 with the defaults.
- Per-channel classifier FSM:
  - States: RELEASED, PRESSED, LONG.
  - RELEASED -> PRESSED when stable rises. press_pulse = 1 for that cycle; the hold counter loads 1.
  - PRESSED: the hold counter increments each cycle stable = 1. It has width $clog2(LONG_PRESS_CYCLES+1) and saturates.
  - PRESSED -> LONG when the hold counter reaches LONG_PRESS_CYCLES. long_pulse = 1 for exactly one cycle.
  - PRESSED -> RELEASED on stable fall: short press.
  - LONG -> RELEASED on stable fall: no flag change.
- Flag update, toggle channel:
  - Short press: mode_flag inverts at the edge where stable falls, i.e. on release.
  - Long press: mode_flag is forced to 0 at the edge where long_pulse asserts.
- Flag update, momentary channel: mode_flag = stable, gated by enable (it holds its value while enable = 0). long_pulse still fires.
- enable = 0: flags hold, but the FSM, pulses and stable_o all run. A release that occurs while enable = 0 does not toggle, even if the press began while enabled.
- Priority, per flag: sync_reset > clear_all > long-force-off > short-toggle > hold.
  - clear_all and a release in the same cycle: flag = 0.
- Channels are fully independent. Simultaneous presses on several channels are each handled in the same cycle.

Decomposition:
- Shared package t09_mode_pkg:
  - classifier state enum: RELEASED, PRESSED, LONG;
  - default-parameter constants;
  - a function for the counter width.
- One natural sub-module, t09_button_channel: synchroniser, debounce, classifier and flag for a single channel, including its TOGGLE_MASK bit.
- The top level contains only a generate loop over NUM_CH plus broadcast of enable and clear_all.

Test Plan (defaults):
- Reset: hold sync_reset high 3 cycles with button_i = 4'hF.
  - All outputs are 0 throughout reset.
  - After release of reset, press_pulse = 4'hF exactly 6 edges later.
- Glitch rejection: button_i[0] high for 3 cycles, then low.
  - stable_o, press_pulse and mode_flag stay 0.
  - A 4-cycle pulse flips stable_o[0].
- Short press: button_i[1] high for 10 cycles.
  - press_pulse[1] fires once.
  - mode_flag[1] goes 0 -> 1 on release.
  - A second identical press returns it to 0.
  - long_pulse[1] never fires.
- Long press: set mode_flag[2] = 1 via a short press, then hold button_i[2] for 30 cycles.
  - long_pulse[2] fires once, 15 cycles after press_pulse[2].
  - mode_flag[2] goes to 0 at that edge and stays 0 after release.
- enable/clear interaction:
  - Short press on channel 3 with enable = 0: mode_flag[3] unchanged.
  - Short press with enable = 1 and clear_all asserted in the release cycle: mode_flag[3] = 0.
- Momentary channel (TOGGLE_MASK = 4'b0111): hold button_i[3] for 20 cycles.
  - mode_flag[3] tracks stable_o[3].
  - long_pulse[3] fires once.
  - Channels 0 to 2 are pressed simultaneously and toggle independently.
